// File: rtl/sr_dmem_arbiter.sv
// Round-robin arbiter sharing one combinational byte/half/word data RAM between
// the CPU data port (m0) and a debug/loader port (m1); one access every 3 cycles.
module sr_dmem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic              m0_we,
  input  logic              m0_sign,
  input  logic [1:0]        m0_size,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic              m1_we,
  input  logic              m1_sign,
  input  logic [1:0]        m1_size,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,

  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  output logic              ram_sign,
  output logic              ram_op_word,
  output logic              ram_op_half,
  output logic              ram_op_byte,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, GNT, RESP} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              we;
    logic              sign;
    logic [1:0]        size;
    logic              port;
  } cmd_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic        last_q, last_d;  // port granted most recently; reset to m1 so m0 wins the first tie
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        win;
  logic        in_gnt;
  logic [31:0] load_data;

  assign win       = (m0_req & m1_req) ? ~last_q : m1_req;
  assign in_gnt    = (state_q == GNT);
  assign load_data = (cmd_q.size == SIZE_ILL) ? 32'h0 : ram_rdata;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    last_d     = last_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          state_d = GNT;
          last_d  = win;
          cmd_d   = win ? '{m1_addr, m1_wdata, m1_we, m1_sign, m1_size, 1'b1}
                        : '{m0_addr, m0_wdata, m0_we, m0_sign, m0_size, 1'b0};
        end
      end
      GNT: begin
        state_d  = RESP;
        m0_ack_d = ~cmd_q.port;
        m1_ack_d =  cmd_q.port;
        if (!cmd_q.we) begin
          if (cmd_q.port) m1_rdata_d = load_data;
          else            m0_rdata_d = load_data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      last_q     <= 1'b1;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 32'h0;
      m1_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      last_q     <= last_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

  // Address/data hold the last command between accesses; strobes exist only in GNT.
  assign ram_addr    = cmd_q.addr;
  assign ram_wdata   = cmd_q.wdata;
  assign ram_sign    = cmd_q.sign;
  assign ram_op_word = in_gnt & (cmd_q.size == SIZE_WORD);
  assign ram_op_half = in_gnt & (cmd_q.size == SIZE_HALF);
  assign ram_op_byte = in_gnt & (cmd_q.size == SIZE_BYTE);
  assign ram_we      = in_gnt & cmd_q.we & (cmd_q.size != SIZE_ILL) & ~rst;

endmodule

// File: tb/tb_sr_dmem_arbiter.sv
// Directed bench for sr_dmem_arbiter: behavioural byte RAM, a transaction table
// and hand-written sequences for round-robin and reset-during-grant.
module tb_sr_dmem_arbiter;

  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              m0_req, m1_req;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [31:0]       m0_wdata, m1_wdata;
  logic              m0_we, m1_we, m0_sign, m1_sign;
  logic [1:0]        m0_size, m1_size;
  logic              m0_ack, m1_ack;
  logic [31:0]       m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ram_we, ram_sign;
  logic              ram_op_word, ram_op_half, ram_op_byte;
  logic [31:0]       ram_rdata;

  sr_dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_sign(m0_sign), .m0_size(m0_size), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_sign(m1_sign), .m1_size(m1_size), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_sign(ram_sign),
    .ram_op_word(ram_op_word), .ram_op_half(ram_op_half), .ram_op_byte(ram_op_byte),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian 256-byte RAM model, combinational read, write on the rising edge.
  logic [7:0] mem [0:255];
  logic [7:0] ra;
  logic [15:0] rh;
  assign ra = ram_addr[7:0];
  assign rh = {mem[ra + 8'd1], mem[ra]};

  always_comb begin
    ram_rdata = 32'h0;
    if (ram_op_word)      ram_rdata = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
    else if (ram_op_half) ram_rdata = ram_sign ? {{16{rh[15]}}, rh} : {16'h0, rh};
    else if (ram_op_byte) ram_rdata = ram_sign ? {{24{mem[ra][7]}}, mem[ra]} : {24'h0, mem[ra]};
  end

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ra] <= ram_wdata[7:0];
      if (ram_op_half | ram_op_word) mem[ra + 8'd1] <= ram_wdata[15:8];
      if (ram_op_word) begin
        mem[ra + 8'd2] <= ram_wdata[23:16];
        mem[ra + 8'd3] <= ram_wdata[31:24];
      end
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic        sign;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } txn_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic p, input logic we, input logic sg, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er);
    txn_t t;
    t.port = p; t.we = we; t.sign = sg; t.size = sz;
    t.addr = a; t.wdata = wd; t.exp_rdata = er;
    return t;
  endfunction

  function automatic logic [2:0] exp_op(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic ack_of(input logic p);
    return p ? m1_ack : m0_ack;
  endfunction

  function automatic logic [31:0] rdata_of(input logic p);
    return p ? m1_rdata : m0_rdata;
  endfunction

  task automatic drive(input txn_t t, input logic req);
    if (!t.port) begin
      m0_req = req; m0_addr = t.addr; m0_wdata = t.wdata;
      m0_we = t.we; m0_sign = t.sign; m0_size = t.size;
    end else begin
      m1_req = req; m1_addr = t.addr; m1_wdata = t.wdata;
      m1_we = t.we; m1_sign = t.sign; m1_size = t.size;
    end
  endtask

  // One solo transaction: request in IDLE, check the GNT strobes, then wait for the ack.
  task automatic run_txn(input txn_t t, input string tag);
    int lat;
    @(negedge clk);
    drive(t, 1'b1);
    @(negedge clk);
    lat = 1;
    check({tag, "/op"}, {29'h0, ram_op_word, ram_op_half, ram_op_byte}, {29'h0, exp_op(t.size)});
    check({tag, "/we"}, {31'h0, ram_we}, {31'h0, t.we & (t.size != 2'b11)});
    while (!ack_of(t.port) && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, lat, 2);
    check({tag, "/other_ack"}, {31'h0, ack_of(~t.port)}, 32'h0);
    check({tag, "/strobes_off"}, {28'h0, ram_we, ram_op_word, ram_op_half, ram_op_byte}, 32'h0);
    check({tag, "/rdata"}, rdata_of(t.port), t.exp_rdata);
    drive(t, 1'b0);
  endtask

  txn_t vec [12];

  initial begin
    int   n_acks;
    int   cyc;
    logic ack_port [4];
    int   ack_cyc [4];

    rst = 1'b1;
    m0_req = 0; m0_addr = '0; m0_wdata = '0; m0_we = 0; m0_sign = 0; m0_size = '0;
    m1_req = 0; m1_addr = '0; m1_wdata = '0; m1_we = 0; m1_sign = 0; m1_size = '0;

    vec[0]  = mk(0, 1, 0, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0);        // m0 word store
    vec[1]  = mk(0, 0, 0, 2'b10, 32'h10, 32'h0,        32'hDEADBEEF); // m0 word load
    vec[2]  = mk(0, 1, 0, 2'b00, 32'h30, 32'h0000_0080, 32'hDEADBEEF);// byte store 0x80
    vec[3]  = mk(1, 0, 1, 2'b00, 32'h30, 32'h0,        32'hFFFFFF80); // signed byte load
    vec[4]  = mk(1, 0, 0, 2'b00, 32'h30, 32'h0,        32'h00000080); // unsigned byte load
    vec[5]  = mk(1, 1, 0, 2'b01, 32'h40, 32'h1234_8001, 32'h00000080);// half store
    vec[6]  = mk(0, 0, 1, 2'b01, 32'h40, 32'h0,        32'hFFFF8001); // signed half load
    vec[7]  = mk(1, 0, 0, 2'b01, 32'h40, 32'h0,        32'h00008001); // unsigned half load
    vec[8]  = mk(0, 1, 0, 2'b11, 32'h10, 32'h0,        32'hFFFF8001); // illegal-size store
    vec[9]  = mk(0, 0, 0, 2'b10, 32'h10, 32'h0,        32'hDEADBEEF); // memory untouched
    vec[10] = mk(1, 0, 1, 2'b11, 32'h10, 32'h0,        32'h00000000); // illegal-size load
    vec[11] = mk(0, 0, 0, 2'b00, 32'h13, 32'h0,        32'h000000DE); // top byte of word

    repeat (2) @(negedge clk);
    check("reset/acks", {30'h0, m0_ack, m1_ack}, 32'h0);
    check("reset/m0_rdata", m0_rdata, 32'h0);
    check("reset/m1_rdata", m1_rdata, 32'h0);
    check("reset/we_op", {28'h0, ram_we, ram_op_word, ram_op_half, ram_op_byte}, 32'h0);
    check("reset/addr", ram_addr, 32'h0);
    check("reset/wdata_sign", {31'h0, ram_sign} | ram_wdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_txn(vec[i], $sformatf("vec%0d", i));

    // m1 alone, then both held: m0 must win the tie and grants alternate.
    run_txn(mk(1, 0, 0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF), "rr_m1_only");
    @(negedge clk);
    drive(mk(0, 0, 0, 2'b10, 32'h10, 32'h0, 32'h0), 1'b1);
    drive(mk(1, 0, 0, 2'b01, 32'h40, 32'h0, 32'h0), 1'b1);
    n_acks = 0;
    cyc = 0;
    while (n_acks < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (m0_ack && m1_ack) check("rr/dual_ack", 32'h1, 32'h0);
      if (m0_ack || m1_ack) begin
        ack_port[n_acks] = m1_ack;
        ack_cyc[n_acks]  = cyc;
        n_acks++;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    check("rr/ack_count", n_acks, 4);
    for (int i = 0; i < n_acks; i++) begin
      check($sformatf("rr/port%0d", i), {31'h0, ack_port[i]}, (i % 2 == 1) ? 32'h1 : 32'h0);
      check($sformatf("rr/cycle%0d", i), ack_cyc[i], 2 + 3 * i);
    end
    check("rr/m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rr/m1_rdata", m1_rdata, 32'h00008001);

    // Reset raised in GNT of a store: the write and the ack must both vanish.
    run_txn(mk(0, 1, 0, 2'b10, 32'h20, 32'h11223344, 32'hDEADBEEF), "rst_pre");
    @(negedge clk);
    drive(mk(0, 1, 0, 2'b10, 32'h20, 32'hCAFEF00D, 32'h0), 1'b1);
    @(negedge clk);
    check("rst/we_before", {31'h0, ram_we}, 32'h1);
    rst = 1'b1;
    m0_req = 1'b0;
    #1;
    check("rst/we_gated", {31'h0, ram_we}, 32'h0);
    @(negedge clk);
    check("rst/idle_op", {29'h0, ram_op_word, ram_op_half, ram_op_byte}, 32'h0);
    check("rst/no_ack", {30'h0, m0_ack, m1_ack}, 32'h0);
    check("rst/rdata_clr", m0_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst/no_ack_late", {30'h0, m0_ack, m1_ack}, 32'h0);
    run_txn(mk(0, 0, 0, 2'b10, 32'h20, 32'h0, 32'h11223344), "rst_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
